uart_fifo_ctrl: RTL and testbench

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

---
 rtl/uart_fifo_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: UART transmitter/receiver with TX and RX FIFOs.
//   clk, rst        : clock, asynchronous active-high reset
//   baud_div        : bit period = max(baud_div,3)+1 clk cycles
//   cfg_dbits       : data bits 5..8; cfg_parity: none/even/odd; cfg_stop2: 2 TX stop bits
//   tx_data/valid   : TX FIFO write port; tx_ready = not full; tx_busy; tx_level
//   rx_data/perr/ferr/valid/ready/level : first-word-fall-through RX FIFO read port
//   rx_overrun      : sticky drop flag, cleared by ovr_clr
//   uart_rxd/txd    : serial input (asynchronous) and registered serial output
module uart_fifo_ctrl #(
   parameter int unsigned TX_DEPTH = 16,
   parameter int unsigned RX_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [15:0]               baud_div,
   input  logic [1:0]                cfg_dbits,
   input  logic [1:0]                cfg_parity,
   input  logic                      cfg_stop2,
   input  logic [7:0]                tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      tx_busy,
   output logic [$clog2(TX_DEPTH):0] tx_level,
   output logic [7:0]                rx_data,
   output logic                      rx_perr,
   output logic                      rx_ferr,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic [$clog2(RX_DEPTH):0] rx_level,
   output logic                      rx_overrun,
   input  logic                      ovr_clr,
   input  logic                      uart_rxd,
   output logic                      uart_txd
);
   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned TX_LW = TX_AW + 1;
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned RX_LW = RX_AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [15:0] bd_eff, half_m1;
   logic [7:0]  dmask;

   always_comb begin
      bd_eff  = (baud_div < 16'd3) ? 16'd3 : baud_div;
      half_m1 = (bd_eff >> 1) + {15'd0, bd_eff[0]} - 16'd1;
      dmask   = 8'hFF >> (2'd3 - cfg_dbits);
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wp, tx_rp;
   logic             tx_push, tx_pop, tx_empty;
   logic [7:0]       tx_head;

   assign tx_ready = (tx_level != TX_LW'(TX_DEPTH));
   assign tx_empty = (tx_level == '0);
   assign tx_push  = tx_valid && tx_ready;
   assign tx_head  = tx_mem[tx_rp];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_level <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
         if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_level <= tx_level + TX_LW'(1);
            2'b01:   tx_level <= tx_level - TX_LW'(1);
            default: tx_level <= tx_level;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   state_t      tx_state;
   logic [15:0] tx_cnt, tx_bd;
   logic [7:0]  tx_shift;
   logic [2:0]  tx_bit_idx, tx_nbits_m1;
   logic        tx_par_en, tx_par_bit, tx_stop2, tx_stop_idx;
   logic        tx_bit_end, tx_line;

   assign tx_bit_end = (tx_cnt == tx_bd);
   assign tx_busy    = !tx_empty || (tx_state != S_IDLE);

   always_comb begin
      tx_pop = 1'b0;
      if (!tx_empty) begin
         if (tx_state == S_IDLE)
            tx_pop = 1'b1;
         else if (tx_state == S_STOP && tx_bit_end && (tx_stop_idx || !tx_stop2))
            tx_pop = 1'b1;
      end
      case (tx_state)
         S_START:  tx_line = 1'b0;
         S_DATA:   tx_line = tx_shift[0];
         S_PARITY: tx_line = tx_par_bit;
         default:  tx_line = 1'b1;
      endcase
   end

   // uart_txd is registered from the state's line value, so the wire trails
   // the FSM by one clock; this gives the two-edge start latency and keeps
   // back-to-back frames gap-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state    <= S_IDLE;
         tx_cnt      <= '0;
         tx_bd       <= '0;
         tx_shift    <= '0;
         tx_bit_idx  <= '0;
         tx_nbits_m1 <= '0;
         tx_par_en   <= 1'b0;
         tx_par_bit  <= 1'b0;
         tx_stop2    <= 1'b0;
         tx_stop_idx <= 1'b0;
         uart_txd    <= 1'b1;
      end else begin
         uart_txd <= tx_line;
         if (tx_pop) begin
            tx_state    <= S_START;
            tx_cnt      <= '0;
            tx_bd       <= bd_eff;
            tx_shift    <= tx_head & dmask;
            tx_nbits_m1 <= {1'b1, cfg_dbits};
            tx_par_en   <= cfg_parity[1];
            tx_par_bit  <= (^(tx_head & dmask)) ^ cfg_parity[0];
            tx_stop2    <= cfg_stop2;
            tx_stop_idx <= 1'b0;
         end else if (tx_state != S_IDLE) begin
            if (!tx_bit_end) begin
               tx_cnt <= tx_cnt + 16'd1;
            end else begin
               tx_cnt <= '0;
               case (tx_state)
                  S_START: begin
                     tx_state   <= S_DATA;
                     tx_bit_idx <= '0;
                  end
                  S_DATA: begin
                     tx_shift <= tx_shift >> 1;
                     if (tx_bit_idx == tx_nbits_m1)
                        tx_state <= tx_par_en ? S_PARITY : S_STOP;
                     else
                        tx_bit_idx <= tx_bit_idx + 3'd1;
                  end
                  S_PARITY: tx_state <= S_STOP;
                  S_STOP: begin
                     if (tx_stop2 && !tx_stop_idx) tx_stop_idx <= 1'b1;
                     else                          tx_state    <= S_IDLE;
                  end
                  default: tx_state <= S_IDLE;
               endcase
            end
         end
      end
   end

   // ---------------- RX synchroniser + FSM ----------------
   logic [1:0]  rx_sync;
   logic        rxs, rx_prev;
   state_t      rx_state;
   logic [15:0] rx_cnt, rx_bd, rx_half_m1;
   logic [2:0]  rx_bit_idx, rx_nbits_m1;
   logic        rx_par_en, rx_par_odd, rx_perr_acc;
   logic [7:0]  rx_shift;
   logic        rx_sample, rx_push;
   logic [9:0]  rx_word;

   assign rxs = rx_sync[1];

   always_comb begin
      rx_sample = (rx_state == S_START) ? (rx_cnt == rx_half_m1) : (rx_cnt == rx_bd);
      rx_push   = (rx_state == S_STOP) && rx_sample;
      rx_word   = {rx_perr_acc, ~rxs, rx_shift};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync     <= 2'b11;
         rx_prev     <= 1'b1;
         rx_state    <= S_IDLE;
         rx_cnt      <= '0;
         rx_bd       <= '0;
         rx_half_m1  <= '0;
         rx_bit_idx  <= '0;
         rx_nbits_m1 <= '0;
         rx_par_en   <= 1'b0;
         rx_par_odd  <= 1'b0;
         rx_perr_acc <= 1'b0;
         rx_shift    <= '0;
      end else begin
         rx_sync <= {rx_sync[0], uart_rxd};
         rx_prev <= rxs;
         if (rx_state == S_IDLE) begin
            if (rx_prev && !rxs) begin
               rx_state    <= S_START;
               rx_cnt      <= '0;
               rx_bd       <= bd_eff;
               rx_half_m1  <= half_m1;
               rx_nbits_m1 <= {1'b1, cfg_dbits};
               rx_par_en   <= cfg_parity[1];
               rx_par_odd  <= cfg_parity[0];
               rx_perr_acc <= 1'b0;
               rx_shift    <= '0;
            end
         end else if (!rx_sample) begin
            rx_cnt <= rx_cnt + 16'd1;
         end else begin
            rx_cnt <= '0;
            case (rx_state)
               S_START: begin
                  rx_state   <= rxs ? S_IDLE : S_DATA;
                  rx_bit_idx <= '0;
               end
               S_DATA: begin
                  rx_shift[rx_bit_idx] <= rxs;
                  if (rx_bit_idx == rx_nbits_m1)
                     rx_state <= rx_par_en ? S_PARITY : S_STOP;
                  else
                     rx_bit_idx <= rx_bit_idx + 3'd1;
               end
               S_PARITY: begin
                  rx_perr_acc <= (^rx_shift) ^ rxs ^ rx_par_odd;
                  rx_state    <= S_STOP;
               end
               default: rx_state <= S_IDLE;
            endcase
         end
      end
   end

   // ---------------- RX FIFO ----------------
   logic [9:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wp, rx_rp;
   logic             rx_full, rx_pop, rx_wr;
   logic [9:0]       rx_head;

   assign rx_valid = (rx_level != '0);
   assign rx_full  = (rx_level == RX_LW'(RX_DEPTH));
   assign rx_pop   = rx_ready && rx_valid;
   assign rx_wr    = rx_push && (!rx_full || rx_pop);

   always_comb begin
      rx_head = rx_mem[rx_rp];
      {rx_perr, rx_ferr, rx_data} = rx_valid ? rx_head : '0;
   end

   always_ff @(posedge clk) begin
      if (rx_wr) rx_mem[rx_wp] <= rx_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wp      <= '0;
         rx_rp      <= '0;
         rx_level   <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_wr)  rx_wp <= rx_wp + RX_AW'(1);
         if (rx_pop) rx_rp <= rx_rp + RX_AW'(1);
         case ({rx_wr, rx_pop})
            2'b10:   rx_level <= rx_level + RX_LW'(1);
            2'b01:   rx_level <= rx_level - RX_LW'(1);
            default: rx_level <= rx_level;
         endcase
         if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
         else if (ovr_clr)                  rx_overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench for uart_fifo_ctrl: TX frame table, RX frame table, loopback,
// RX overrun, TX full/back-to-back, and reset mid-frame with an RX glitch.
module tb_uart_fifo_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic [1:0]  cfg_dbits, cfg_parity;
   logic        cfg_stop2;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_busy;
   logic [4:0]  tx_level;
   logic [7:0]  rx_data;
   logic        rx_perr, rx_ferr, rx_valid, rx_ready;
   logic [2:0]  rx_level;
   logic        rx_overrun, ovr_clr, uart_rxd, uart_txd;
   logic        loop, rxd_drv;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [9:0] exp_q [$];
   logic [7:0] tx_q [$];

   always #5 clk = ~clk;
   assign uart_rxd = loop ? uart_txd : rxd_drv;

   uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_dbits(cfg_dbits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
      .tx_level(tx_level), .rx_data(rx_data), .rx_perr(rx_perr),
      .rx_ferr(rx_ferr), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_level(rx_level), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
      .uart_rxd(uart_rxd), .uart_txd(uart_txd)
   );

   typedef struct {
      logic [7:0]  d;
      logic [1:0]  db;
      logic [1:0]  par;
      logic        stop2;
      logic [15:0] baud;
      logic [11:0] frame;   // transmit order, first bit leftmost
      int unsigned len;
   } tx_vec_t;

   typedef struct {
      logic [7:0] d;
      logic [1:0] db;
      logic [1:0] par;
      logic       flip;
      logic       stop_low;
      logic [9:0] exp;      // {perr, ferr, data}
   } rx_vec_t;

   tx_vec_t tx_tab [5];
   rx_vec_t rx_tab [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int unsigned period(input logic [15:0] b);
      return (b < 16'd3) ? 4 : 32'(b) + 1;
   endfunction

   task automatic wr_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic capture_tx(input int unsigned len, input int unsigned p,
                             output logic [11:0] act, output int unsigned lat);
      act = '0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (uart_txd === 1'b1 && lat < 3000);
      repeat (p / 2) @(posedge clk);
      @(negedge clk);
      act = {act[10:0], uart_txd};
      for (int unsigned i = 1; i < len; i++) begin
         repeat (p) @(negedge clk);
         act = {act[10:0], uart_txd};
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                          input logic flip, input logic stop_low, input int unsigned p);
      int unsigned n;
      logic pb;
      n  = 32'(db) + 5;
      pb = par[0] ^ flip;
      @(negedge clk);
      rxd_drv = 1'b0;
      repeat (p) @(negedge clk);
      for (int unsigned i = 0; i < n; i++) begin
         rxd_drv = d[i];
         pb      = pb ^ d[i];
         repeat (p) @(negedge clk);
      end
      if (par[1]) begin
         rxd_drv = pb;
         repeat (p) @(negedge clk);
      end
      rxd_drv = !stop_low;
      repeat (p) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (2 * p) @(negedge clk);
   endtask

   task automatic expect_rx(input string name);
      int unsigned n;
      logic [31:0] e;
      n = 0;
      while (!rx_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, 32'(rx_valid), 1);
      e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
      check(name, 32'({rx_perr, rx_ferr, rx_data}), e);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic [11:0] act;
      int unsigned lat, p, peak;
      logic txd_low, rxv_seen;

      tx_tab[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 16'd15, 12'b0101001011,  10};
      tx_tab[1] = '{8'h3C, 2'd2, 2'd2, 1'b1, 16'd7,  12'b00011110011, 11};
      tx_tab[2] = '{8'hFF, 2'd0, 2'd3, 1'b0, 16'd7,  12'b01111101,    8};
      tx_tab[3] = '{8'h2B, 2'd1, 2'd3, 1'b1, 16'd7,  12'b0110101111,  10};
      tx_tab[4] = '{8'h80, 2'd2, 2'd0, 1'b0, 16'd2,  12'b000000001,   9};

      rx_tab[0] = '{8'h55, 2'd3, 2'd3, 1'b1, 1'b0, 10'h255};
      rx_tab[1] = '{8'h12, 2'd3, 2'd3, 1'b0, 1'b1, 10'h112};
      rx_tab[2] = '{8'hF3, 2'd0, 2'd0, 1'b0, 1'b0, 10'h013};
      rx_tab[3] = '{8'h6A, 2'd1, 2'd2, 1'b0, 1'b0, 10'h02A};

      rst = 1'b1; baud_div = 16'd15; cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0;
      loop = 1'b0; rxd_drv = 1'b1;

      #12;
      check("rst_txd", 32'(uart_txd), 1);
      check("rst_tx_ready", 32'(tx_ready), 1);
      check("rst_tx_busy", 32'(tx_busy), 0);
      check("rst_levels", 32'({tx_level, rx_level}), 0);
      check("rst_rx_out", 32'({rx_valid, rx_overrun, rx_perr, rx_ferr, rx_data}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // TX frame table
      for (int i = 0; i < 5; i++) begin
         baud_div   = tx_tab[i].baud;
         cfg_dbits  = tx_tab[i].db;
         cfg_parity = tx_tab[i].par;
         cfg_stop2  = tx_tab[i].stop2;
         p = period(tx_tab[i].baud);
         wr_tx(tx_tab[i].d);
         check("tx_busy_on", 32'(tx_busy), 1);
         capture_tx(tx_tab[i].len, p, act, lat);
         check("tx_start_latency", lat, 2);
         check("tx_frame", 32'(act), 32'(tx_tab[i].frame));
         repeat (p / 2 + 2) @(negedge clk);
         check("tx_busy_off", 32'({tx_busy, uart_txd}), 1);
      end

      // RX frame table
      baud_div = 16'd7;
      for (int i = 0; i < 4; i++) begin
         cfg_dbits  = rx_tab[i].db;
         cfg_parity = rx_tab[i].par;
         exp_q.push_back(rx_tab[i].exp);
         send_rx(rx_tab[i].d, rx_tab[i].db, rx_tab[i].par, rx_tab[i].flip, rx_tab[i].stop_low, 8);
         check("rx_level_one", 32'(rx_level), 1);
         expect_rx("rx_word");
         check("rx_empty_after_pop", 32'(rx_valid), 0);
      end

      // Loopback 7E2
      loop = 1'b1; baud_div = 16'd15; cfg_dbits = 2'd2; cfg_parity = 2'd2; cfg_stop2 = 1'b1;
      exp_q.push_back(10'h03C);
      exp_q.push_back(10'h07F);
      wr_tx(8'h3C);
      wr_tx(8'h7F);
      peak = 0;
      for (int n = 0; n < 2000 && rx_level != 3'd2; n++) begin
         @(negedge clk);
         if (32'(rx_level) > peak) peak = 32'(rx_level);
      end
      repeat (50) begin
         @(negedge clk);
         if (32'(rx_level) > peak) peak = 32'(rx_level);
      end
      check("loop_peak_level", peak, 2);
      expect_rx("loop_word0");
      expect_rx("loop_word1");
      loop = 1'b0;

      // RX overrun with depth 4
      baud_div = 16'd7; cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) exp_q.push_back({2'b00, 8'hA1 + 8'(k)});
         send_rx(8'hA1 + 8'(k), 2'd3, 2'd0, 1'b0, 1'b0, 8);
      end
      check("ovr_level", 32'(rx_level), 4);
      check("ovr_flag", 32'(rx_overrun), 1);
      for (int k = 0; k < 4; k++) expect_rx("ovr_word");
      check("ovr_sticky", 32'(rx_overrun), 1);
      @(negedge clk); ovr_clr = 1'b1;
      @(negedge clk); ovr_clr = 1'b0;
      check("ovr_cleared", 32'(rx_overrun), 0);

      // TX full and back-to-back, baud_div below the minimum
      baud_div = 16'd0;
      fork
         begin
            for (int k = 0; k < 17; k++) begin
               @(negedge clk);
               tx_data  = 8'h10 + 8'(k);
               tx_valid = 1'b1;
               tx_q.push_back(tx_data);
            end
            @(negedge clk);
            check("full_ready", 32'(tx_ready), 0);
            check("full_level", 32'(tx_level), 16);
            tx_data = 8'hEE;
            @(negedge clk);
            tx_valid = 1'b0;
            check("full_level_after_extra", 32'(tx_level), 16);
         end
         begin
            logic [7:0] d;
            logic s0, s1;
            logic [31:0] e;
            int unsigned n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (uart_txd === 1'b1 && n < 500);
            check("b2b_start_seen", 32'(uart_txd), 0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            for (int f = 0; f < 17; f++) begin
               d = '0;
               s0 = 1'b1;
               s1 = 1'b0;
               for (int b = 0; b < 10; b++) begin
                  if (f != 0 || b != 0) repeat (4) @(negedge clk);
                  if (b == 0)      s0 = uart_txd;
                  else if (b == 9) s1 = uart_txd;
                  else             d[b-1] = uart_txd;
               end
               e = (tx_q.size() != 0) ? 32'(tx_q.pop_front()) : 32'hDEAD;
               check("b2b_data", 32'(d), e);
               check("b2b_framing", 32'({s0, s1}), 1);
            end
            txd_low = 1'b0;
            repeat (60) begin
               @(negedge clk);
               if (!uart_txd) txd_low = 1'b1;
            end
            check("b2b_no_extra_frame", 32'({txd_low, tx_busy}), 0);
         end
      join

      // Reset during DATA bit 3, then an RX glitch
      baud_div = 16'd15; cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      wr_tx(8'h00);
      wr_tx(8'hFF);
      capture_tx(1, 16, act, lat);
      repeat (16 * 3) @(negedge clk);
      check("pre_rst_txd", 32'(uart_txd), 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_txd", 32'(uart_txd), 1);
      check("mid_rst_tx", 32'({tx_busy, tx_ready, tx_level}), 32'h20);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rxd_drv = 1'b0;
      repeat (4) @(negedge clk);
      rxd_drv = 1'b1;
      txd_low = 1'b0;
      rxv_seen = 1'b0;
      repeat (400) begin
         @(negedge clk);
         if (!uart_txd) txd_low = 1'b1;
         if (rx_valid) rxv_seen = 1'b1;
      end
      check("post_rst_txd_quiet", 32'(txd_low), 0);
      check("glitch_no_push", 32'({rxv_seen, rx_level}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
